tx_huge_page_sched: RTL and testbench

Sequences transmit reads out of the two host huge pages. When the host unlocks a page (its status goes high), the block walks that page from its base address. It issues bounded memory-read requests to the TX read-request TLP generator and tracks outstanding completions. Once the whole page has been fetched and consumed, it pulses the page's free strobe back to the huge-page address/status register block. Pages are serviced in strict alternation: 1, 2, 1, 2, …

---
 rtl/tx_sched_pkg.sv | 15 +
 rtl/tx_rd_chunk_calc.sv | 31 +++
 rtl/tx_huge_page_sched.sv | 175 +++++++++++++++++
 tb/tb_tx_huge_page_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared state encoding and widths for the huge-page TX read scheduler.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        DRAIN,
        FREE
    } state_t;

    localparam int BOUNDARY_BYTES = 4096;
    localparam int RDQW_W         = 10;

endpackage

// File: rtl/tx_rd_chunk_calc.sv
// tx_rd_chunk_calc: size of the next read request, min(remaining, MAX_RD_QW[, qwords to next 4 KB]).
// The 4 KB term exists only when TX_SCHED_4K_SPLIT_EN is defined.
module tx_rd_chunk_calc
    import tx_sched_pkg::*;
#(
    parameter int MAX_RD_QW = 64
) (
`ifdef TX_SCHED_4K_SPLIT_EN
    input  logic [11:0]       i_addr_lo,
`endif
    input  logic [31:0]       i_rem,
    output logic [RDQW_W-1:0] o_chunk
);

    localparam logic [31:0] MAX_QW = 32'(MAX_RD_QW);

    logic [RDQW_W-1:0] w_cap;

    assign w_cap = (i_rem < MAX_QW) ? i_rem[RDQW_W-1:0] : MAX_QW[RDQW_W-1:0];

`ifdef TX_SCHED_4K_SPLIT_EN
    logic [RDQW_W-1:0] w_bnd;

    // Distance to the next 4 KB line is at most 512 qwords, so it fits the request width.
    assign w_bnd   = RDQW_W'((13'(BOUNDARY_BYTES) - {1'b0, i_addr_lo}) >> 3);
    assign o_chunk = (w_bnd < w_cap) ? w_bnd : w_cap;
`else
    assign o_chunk = w_cap;
`endif

endmodule

// File: rtl/tx_huge_page_sched.sv
// tx_huge_page_sched: walks host huge pages 1,2,1,2,... issuing bounded read requests and
// freeing each page once all its completions are consumed. Optional TX_SCHED_4K_SPLIT_EN
// keeps every request inside a single 4 KB line.
module tx_huge_page_sched
    import tx_sched_pkg::*;
#(
    parameter int MAX_RD_QW       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              trn_clk,
    input  logic              reset,
    input  logic [63:0]       huge_page_addr_1,
    input  logic [63:0]       huge_page_addr_2,
    input  logic [31:0]       huge_page_qwords_1,
    input  logic [31:0]       huge_page_qwords_2,
    input  logic              huge_page_status_1,
    input  logic              huge_page_status_2,
    output logic              huge_page_free_1,
    output logic              huge_page_free_2,
    output logic              rd_req,
    output logic [63:0]       rd_addr,
    output logic [RDQW_W-1:0] rd_qwords,
    input  logic              rd_ack,
    input  logic              rd_cpl_done,
    output logic              busy
);

    localparam logic [5:0] MAX_OUT = 6'(MAX_OUTSTANDING);

    state_t            r_state;
    logic              r_cur_page2;
    logic [5:0]        r_out;
    logic [31:0]       r_rem;
    logic              r_rd_req;
    logic [63:0]       r_rd_addr;
    logic [RDQW_W-1:0] r_rd_qwords;
    logic              r_free_1;
    logic              r_free_2;
    logic              r_busy;

    logic              w_status;
    logic [63:0]       w_page_addr;
    logic [31:0]       w_page_qwords;
    logic              w_ack;
    logic              w_cpl;
    logic [5:0]        w_out_next;
    logic              w_can_req;
    logic [63:0]       w_next_addr;
    logic [31:0]       w_next_rem;
    logic [31:0]       w_calc_rem;
    logic [RDQW_W-1:0] w_chunk;

    assign w_status      = r_cur_page2 ? huge_page_status_2 : huge_page_status_1;
    assign w_page_addr   = r_cur_page2 ? huge_page_addr_2   : huge_page_addr_1;
    assign w_page_qwords = r_cur_page2 ? huge_page_qwords_2 : huge_page_qwords_1;

    // An ack only counts against a request actually on offer; a completion at zero is dropped.
    assign w_ack      = rd_ack & r_rd_req;
    assign w_cpl      = rd_cpl_done & (r_out != 6'd0);
    assign w_out_next = r_out + {5'd0, w_ack} - {5'd0, w_cpl};
    assign w_can_req  = w_out_next < MAX_OUT;

    assign w_next_addr = r_rd_addr + (64'(r_rd_qwords) << 3);
    assign w_next_rem  = r_rem - 32'(r_rd_qwords);

    // LOAD sizes the first request straight from the page inputs; REQ sizes the one after an ack.
    assign w_calc_rem = (r_state == LOAD) ? w_page_qwords : w_next_rem;

`ifdef TX_SCHED_4K_SPLIT_EN
    logic [11:0] w_calc_addr_lo;

    assign w_calc_addr_lo = (r_state == LOAD) ? w_page_addr[11:0] : w_next_addr[11:0];

    tx_rd_chunk_calc #(
        .MAX_RD_QW (MAX_RD_QW)
    ) u_chunk (
        .i_addr_lo (w_calc_addr_lo),
        .i_rem     (w_calc_rem),
        .o_chunk   (w_chunk)
    );
`else
    tx_rd_chunk_calc #(
        .MAX_RD_QW (MAX_RD_QW)
    ) u_chunk (
        .i_rem     (w_calc_rem),
        .o_chunk   (w_chunk)
    );
`endif

    assign huge_page_free_1 = r_free_1;
    assign huge_page_free_2 = r_free_2;
    assign rd_req           = r_rd_req;
    assign rd_addr          = r_rd_addr;
    assign rd_qwords        = r_rd_qwords;
    assign busy             = r_busy;

    // Count issued-but-uncompleted requests; ack and completion together cancel out.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_out <= 6'd0;
        end else begin
            r_out <= w_out_next;
        end
    end

    // Page sequencer: latch page, issue chunks under the outstanding cap, drain, free, alternate.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur_page2 <= 1'b0;
            r_rem       <= 32'd0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= 64'd0;
            r_rd_qwords <= '0;
            r_free_1    <= 1'b0;
            r_free_2    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_free_1 <= 1'b0;
            r_free_2 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_status) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_rd_addr   <= w_page_addr;
                    r_rem       <= w_page_qwords;
                    r_rd_qwords <= w_chunk;
                    if (w_page_qwords == 32'd0) begin
                        r_state  <= FREE;
                        r_free_1 <= ~r_cur_page2;
                        r_free_2 <= r_cur_page2;
                    end else begin
                        r_state  <= REQ;
                        r_rd_req <= w_can_req;
                    end
                end
                REQ: begin
                    if (w_ack) begin
                        r_rd_addr <= w_next_addr;
                        r_rem     <= w_next_rem;
                        if (w_next_rem == 32'd0) begin
                            r_state  <= DRAIN;
                            r_rd_req <= 1'b0;
                        end else begin
                            r_rd_qwords <= w_chunk;
                            r_rd_req    <= w_can_req;
                        end
                    end else begin
                        r_rd_req <= w_can_req;
                    end
                end
                DRAIN: begin
                    if (w_out_next == 6'd0) begin
                        r_state  <= FREE;
                        r_free_1 <= ~r_cur_page2;
                        r_free_2 <= r_cur_page2;
                    end
                end
                FREE: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cur_page2 <= ~r_cur_page2;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// tb_tx_huge_page_sched: table-driven page runs with a request scoreboard plus corner-case sequences.
module tb_tx_huge_page_sched;

    localparam int MAXQ = 64;
    localparam int MAXO = 2;
`ifdef TX_SCHED_4K_SPLIT_EN
    localparam bit SPL = 1'b1;
`else
    localparam bit SPL = 1'b0;
`endif

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] huge_page_addr_1 = '0;
    logic [63:0] huge_page_addr_2 = '0;
    logic [31:0] huge_page_qwords_1 = '0;
    logic [31:0] huge_page_qwords_2 = '0;
    logic        huge_page_status_1 = 1'b0;
    logic        huge_page_status_2 = 1'b0;
    logic        huge_page_free_1;
    logic        huge_page_free_2;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic [9:0]  rd_qwords;
    logic        rd_ack = 1'b0;
    logic        rd_cpl_done = 1'b0;
    logic        busy;

    always #5 trn_clk = ~trn_clk;

    tx_huge_page_sched #(
        .MAX_RD_QW       (MAXQ),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .trn_clk            (trn_clk),
        .reset              (reset),
        .huge_page_addr_1   (huge_page_addr_1),
        .huge_page_addr_2   (huge_page_addr_2),
        .huge_page_qwords_1 (huge_page_qwords_1),
        .huge_page_qwords_2 (huge_page_qwords_2),
        .huge_page_status_1 (huge_page_status_1),
        .huge_page_status_2 (huge_page_status_2),
        .huge_page_free_1   (huge_page_free_1),
        .huge_page_free_2   (huge_page_free_2),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_qwords          (rd_qwords),
        .rd_ack             (rd_ack),
        .rd_cpl_done        (rd_cpl_done),
        .busy               (busy)
    );

    typedef struct {
        logic [63:0] addr;
        logic [9:0]  qw;
    } req_t;

    typedef struct {
        logic        p2;
        logic [63:0] addr;
        logic [31:0] qw;
        int          nreq;
    } vec_t;

    req_t exp_q[$];
    vec_t vecs[5];
    int   tests = 0;
    int   fails = 0;
    int   pend = 0;
    int   acks = 0;
    int   cyc = 0;
    int   nfree;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected request stream for one page, sized by the min() rule.
    task automatic push_reqs(input logic [63:0] a, input logic [31:0] q);
        logic [9:0] c;
        logic [9:0] b;
        while (q != 32'd0) begin
            c = (q < 32'(MAXQ)) ? q[9:0] : 10'(MAXQ);
            if (SPL) begin
                b = 10'((64'd4096 - (a % 64'd4096)) / 64'd8);
                if (b < c) c = b;
            end
            exp_q.push_back('{a, c});
            a = a + 64'(c) * 64'd8;
            q = q - 32'(c);
        end
    endtask

    // One clock: update the outstanding model, check/accept any offered request, drive completion.
    task automatic tick(input bit ack_en, input bit cpl);
        req_t e;
        @(posedge trn_clk);
        #1;
        cyc++;
        if (rd_cpl_done && pend > 0) pend--;
        if (rd_ack) pend++;
        rd_ack = 1'b0;
        rd_cpl_done = 1'b0;
        if (rd_req) chk("rd_req_when_full", 64'(pend >= MAXO), 64'd0);
        if (ack_en && rd_req) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL req_unexpected: got addr 0x%0h qw %0d, none expected", rd_addr, rd_qwords);
            end else begin
                e = exp_q.pop_front();
                chk("req_addr", rd_addr, e.addr);
                chk("req_qwords", 64'(rd_qwords), 64'(e.qw));
            end
            rd_ack = 1'b1;
            acks++;
        end
        rd_cpl_done = cpl && (pend > 0);
    endtask

    task automatic run_page(input logic p2, input logic [63:0] a, input logic [31:0] q, input int nreq);
        int first_t;
        int free_t;
        int cpl_t;
        int wrong;
        first_t = -1;
        free_t = -1;
        cpl_t = -1;
        wrong = 0;
        acks = 0;
        push_reqs(a, q);
        if (p2) begin
            huge_page_addr_2 = a;
            huge_page_qwords_2 = q;
            huge_page_status_2 = 1'b1;
        end else begin
            huge_page_addr_1 = a;
            huge_page_qwords_1 = q;
            huge_page_status_1 = 1'b1;
        end
        for (int t = 1; t <= 3000 && free_t < 0; t++) begin
            tick(1'b1, (cyc % 2) == 0);
            if (t == 1) chk("busy_in_load", 64'(busy), 64'd1);
            if (rd_req && first_t < 0) first_t = t;
            if (p2 ? huge_page_free_1 : huge_page_free_2) wrong++;
            if (p2 ? huge_page_free_2 : huge_page_free_1) free_t = t;
            else if (rd_cpl_done) cpl_t = t;
        end
        if (p2) huge_page_status_2 = 1'b0;
        else huge_page_status_1 = 1'b0;
        if (free_t < 0) begin
            tests++;
            fails++;
            $display("FAIL free_timeout: page %0d got no free pulse, required within 3000 cycles", p2 ? 2 : 1);
        end
        chk("free_other_page", 64'(wrong), 64'd0);
        if (q != 32'd0) begin
            chk("first_req_latency", 64'(first_t), 64'd2);
            chk("free_after_last_cpl", 64'(free_t - cpl_t), 64'd1);
        end else begin
            chk("zero_len_free_latency", 64'(free_t), 64'd2);
        end
        chk("req_count", 64'(acks), 64'(nreq));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        tick(1'b0, 1'b0);
        chk("free_width", 64'(p2 ? huge_page_free_2 : huge_page_free_1), 64'd0);
        chk("busy_back_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'h0000_0000_1000_0000, 32'd128, 2};
        vecs[1] = '{1'b1, 64'h0000_0000_2000_0F00, 32'd40, SPL ? 2 : 1};
        vecs[2] = '{1'b0, 64'h0000_0000_0000_0FF0, 32'd8, SPL ? 2 : 1};
        vecs[3] = '{1'b1, 64'h0000_0000_FFFF_FF00, 32'd96, 2};
        vecs[4] = '{1'b0, 64'h0000_0000_5000_0008, 32'd1, 1};

        // Reset values.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_rd_addr", rd_addr, 64'd0);
        chk("rst_rd_qwords", 64'(rd_qwords), 64'd0);
        chk("rst_free_1", 64'(huge_page_free_1), 64'd0);
        chk("rst_free_2", 64'(huge_page_free_2), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Page 2 ready first is ignored while page 1 is the current page.
        huge_page_addr_2 = 64'h9000_0000;
        huge_page_qwords_2 = 32'd5;
        huge_page_status_2 = 1'b1;
        repeat (4) tick(1'b0, 1'b0);
        chk("ignore_status_2_busy", 64'(busy), 64'd0);
        chk("ignore_status_2_req", 64'(rd_req), 64'd0);
        huge_page_status_2 = 1'b0;

        for (int i = 0; i < 5; i++) run_page(vecs[i].p2, vecs[i].addr, vecs[i].qw, vecs[i].nreq);

        // Now waiting on page 2: page 1 status is ignored.
        huge_page_qwords_1 = 32'd3;
        huge_page_status_1 = 1'b1;
        repeat (4) tick(1'b0, 1'b0);
        chk("ignore_status_1_busy", 64'(busy), 64'd0);
        huge_page_status_1 = 1'b0;

        // Zero-length page 2.
        run_page(1'b1, 64'h0000_0000_8000_0000, 32'd0, 0);

        // Outstanding cap of 2 with no completions, then release one at a time.
        acks = 0;
        huge_page_addr_1 = 64'h0000_0000_4000_0000;
        huge_page_qwords_1 = 32'd256;
        push_reqs(huge_page_addr_1, huge_page_qwords_1);
        huge_page_status_1 = 1'b1;
        repeat (10) tick(1'b1, 1'b0);
        chk("cap_acks", 64'(acks), 64'd2);
        chk("cap_req_low", 64'(rd_req), 64'd0);
        tick(1'b1, 1'b1);
        repeat (8) tick(1'b1, 1'b0);
        chk("cap_one_more", 64'(acks), 64'd3);
        chk("cap_req_low_again", 64'(rd_req), 64'd0);
        // Completion frees a slot, then the last request's ack coincides with another completion.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("sim_acks", 64'(acks), 64'd4);
        nfree = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            if (huge_page_free_1) nfree++;
        end
        chk("sim_no_early_free", 64'(nfree), 64'd0);
        chk("sim_still_busy", 64'(busy), 64'd1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("sim_free_after_cpl", 64'(huge_page_free_1), 64'd1);
        huge_page_status_1 = 1'b0;
        tick(1'b0, 1'b0);
        chk("sim_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of page 2 requests.
        acks = 0;
        huge_page_addr_2 = 64'h0000_0000_6000_0000;
        huge_page_qwords_2 = 32'd256;
        push_reqs(huge_page_addr_2, huge_page_qwords_2);
        huge_page_status_2 = 1'b1;
        repeat (3) tick(1'b1, 1'b0);
        rd_ack = 1'b0;
        rd_cpl_done = 1'b0;
        reset = 1'b1;
        @(posedge trn_clk);
        #1;
        chk("mid_rst_rd_req", 64'(rd_req), 64'd0);
        chk("mid_rst_rd_addr", rd_addr, 64'd0);
        chk("mid_rst_rd_qwords", 64'(rd_qwords), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_free_2", 64'(huge_page_free_2), 64'd0);
        exp_q.delete();
        pend = 0;
        @(posedge trn_clk);
        #1;
        chk("mid_rst_no_free", 64'({huge_page_free_1, huge_page_free_2}), 64'd0);
        reset = 1'b0;
        // Both pages ready after reset: page 1 goes first.
        run_page(1'b0, 64'h0000_0000_7000_0000, 32'd64, 1);
        huge_page_status_2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
